// File: rtl/pipelined_addsub.sv
// Add/sub with the carry chain cut into STAGES registered segments; latency STAGES cycles, one op/cycle.
// A stalled output freezes the whole pipe (in_ready = !out_valid || out_ready); `ADDSUB_SAT_EN clamps s on signed overflow.
module pipelined_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES, with 1 <= STAGES <= WIDTH");
  end

  // Operands travel whole down the pipe; stage k only adds its own slice, so the
  // unused low operand bits and unused high result bits fall away in synthesis.
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  r_in [STAGES];
  logic [WIDTH-1:0]  r_nx [STAGES];
  logic [SEG:0]      seg  [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] v_in;

  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;
  logic              ovf_nx;
  logic              advance;

  assign advance   = !v_q[LAST] || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[LAST];
  assign s         = r_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_in[k] = a;
      assign b_in[k] = b ^ {WIDTH{sub}};
      assign r_in[k] = '0;
      assign c_in[k] = cin ^ sub;
      assign v_in[k] = in_valid;
    end else begin : g_body
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign r_in[k] = r_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    assign seg[k] = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                  + {{SEG{1'b0}}, c_in[k]};

    if (k < LAST) begin : g_mid
      assign r_nx[k] = r_in[k] | (WIDTH'(seg[k][SEG-1:0]) << (k*SEG));
    end
  end

  // The top slice is added in the last stage, so sign information is all local here.
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] raw;

  assign raw    = r_in[LAST] | (WIDTH'(seg[LAST][SEG-1:0]) << (LAST*SEG));
  assign a_msb  = a_in[LAST][WIDTH-1];
  assign b_msb  = b_in[LAST][WIDTH-1];
  assign ovf_nx = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);

`ifdef ADDSUB_SAT_EN
  assign r_nx[LAST] = !ovf_nx ? raw
                    : a_msb   ? {1'b1, {(WIDTH-1){1'b0}}}
                    :           {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign r_nx[LAST] = raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        r_q[i] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= a_in[i];
        b_q[i] <= b_in[i];
        r_q[i] <= r_nx[i];
        c_q[i] <= seg[i][SEG];
      end
      v_q   <= v_in;
      ovf_q <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: STAGES=2, 1 and 4 builds share one stimulus stream;
// each is scored against an integer-arithmetic reference model with per-build queues.
module tb_pipelined_addsub;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           cyc;
    int           stl;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [2:0]   co;
  logic [2:0]   ovo;
  logic [W-1:0] so [3];

  exp_t         mem [3][16];
  int           hd [3];
  int           tl [3];
  int           cnt [3];
  int           stl [3];
  int           stg [3];
  logic         acc [3];
  logic         hst [3];
  logic [W+2:0] hv [3];
  int           cyc;
  int           n_chk;
  int           n_err;

  pipelined_addsub #(.WIDTH(W), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(ov[0]), .out_ready(out_ready), .s(so[0]), .cout(co[0]), .ovf(ovo[0])
  );

  pipelined_addsub #(.WIDTH(W), .STAGES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(ov[1]), .out_ready(out_ready), .s(so[1]), .cout(co[1]), .ovf(ovo[1])
  );

  pipelined_addsub #(.WIDTH(W), .STAGES(4)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(ov[2]), .out_ready(out_ready), .s(so[2]), .cout(co[2]), .ovf(ovo[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic msub, input logic mcin);
    exp_t e;
    int   r;
    int   sr;
    if (!msub) begin
      r  = int'(ma) + int'(mb) + int'(mcin);
      sr = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
    end else begin
      r  = int'(ma) - int'(mb) - int'(mcin);
      sr = int'($signed(ma)) - int'($signed(mb)) - int'(mcin);
    end
    e.s   = r[W-1:0];
    e.c   = msub ? (r >= 0) : (r > 255);
    e.o   = (sr > 127) || (sr < -128);
    e.cyc = 0;
    e.stl = 0;
`ifdef ADDSUB_SAT_EN
    if (e.o) e.s = ma[W-1] ? 8'h80 : 8'h7F;
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(5))
      0:       return 8'h00;
      1:       return 8'h7F;
      2:       return 8'h80;
      3:       return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic clear_sb();
    for (int d = 0; d < 3; d++) begin
      hd[d]  = 0;
      tl[d]  = 0;
      cnt[d] = 0;
      hst[d] = 1'b0;
      hv[d]  = '0;
    end
  endtask

  // Called at the falling edge: inputs shown here are what the next rising edge takes.
  task automatic sample();
    exp_t         e;
    logic [W+2:0] cur;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      cur = {ov[d], so[d], co[d], ovo[d]};
      chk($sformatf("in_ready[%0d]", d), 32'(ir[d]), 32'(!ov[d] || out_ready));
      if (hst[d]) chk($sformatf("hold[%0d]", d), 32'(cur), 32'(hv[d]));
      hst[d] = ov[d] && !out_ready;
      hv[d]  = cur;
      if (hst[d]) stl[d]++;
      if (ov[d] && cnt[d] == 0) begin
        chk($sformatf("spurious[%0d]", d), 32'(ov[d]), 32'd0);
      end else if (ov[d] && out_ready) begin
        e      = mem[d][hd[d]];
        hd[d]  = (hd[d] + 1) % 16;
        cnt[d] = cnt[d] - 1;
        chk($sformatf("s[%0d]", d), 32'(so[d]), 32'(e.s));
        chk($sformatf("cout[%0d]", d), 32'(co[d]), 32'(e.c));
        chk($sformatf("ovf[%0d]", d), 32'(ovo[d]), 32'(e.o));
        if (e.stl == stl[d]) chk($sformatf("latency[%0d]", d), 32'(cyc - e.cyc), 32'(stg[d]));
      end
      acc[d] = in_valid && ir[d];
      if (acc[d]) begin
        e            = model(a, b, sub, cin);
        e.cyc        = cyc;
        e.stl        = stl[d];
        mem[d][tl[d]] = e;
        tl[d]        = (tl[d] + 1) % 16;
        cnt[d]       = cnt[d] + 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((cnt[0] + cnt[1] + cnt[2]) != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(cnt[0] + cnt[1] + cnt[2]), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_out_valid[%0d]", tag, d), 32'(ov[d]), 32'd0);
      chk($sformatf("%s_s[%0d]", tag, d), 32'(so[d]), 32'd0);
      chk($sformatf("%s_cout[%0d]", tag, d), 32'(co[d]), 32'd0);
      chk($sformatf("%s_ovf[%0d]", tag, d), 32'(ovo[d]), 32'd0);
      chk($sformatf("%s_in_ready[%0d]", tag, d), 32'(ir[d]), 32'd1);
    end
  endtask

  // Single op into an idle pipe; the STAGES=2 build must show it two edges later.
  task automatic send_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tsub, input logic tcin,
                            input logic [W-1:0] es, input logic ec, input logic eo);
    a        = ta;
    b        = tb_;
    sub      = tsub;
    cin      = tcin;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk({tag, "_valid"}, 32'(ov[0]), 32'd1);
    chk({tag, "_s"}, 32'(so[0]), 32'(es));
    chk({tag, "_cout"}, 32'(co[0]), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovo[0]), 32'(eo));
  endtask

  initial begin
    int idx;
    int left;
    int n;
    logic started;

    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    stg[0] = 2;
    stg[1] = 1;
    stg[2] = 4;
    for (int d = 0; d < 3; d++) begin
      stl[d] = 0;
      acc[d] = 1'b0;
    end
    clear_sb();

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    cin       = 1'b0;
    #2;
    chk_reset("reset");
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_check("t1_sub", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    send_check("t2_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
    send_check("t2_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1);
`else
    send_check("t2_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
`endif
    drain();

    // Four back-to-back ops; three-cycle downstream stall once the first result shows.
    idx     = 0;
    left    = 3;
    n       = 0;
    started = 1'b0;
    while ((idx < 4 || left > 0) && n < 30) begin
      in_valid = (idx < 4);
      a        = W'(49 * (idx + 1));
      b        = W'(91 + 7 * idx);
      sub      = idx[0];
      cin      = idx[1];
      if (ov[0]) started = 1'b1;
      out_ready = !(started && left > 0);
      if (!out_ready) begin
        left--;
        #1;
        chk("t3_stall_in_ready", 32'(ir[0]), 32'd0);
      end
      step();
      if (acc[0]) idx++;
      n++;
    end
    chk("t3_accepted", 32'(idx), 32'd4);
    chk("t3_stall_seen", 32'(left), 32'd0);
    drain();

    // Asynchronous reset between edges with work in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a        = pick();
      b        = pick();
      sub      = 1'($urandom_range(1));
      cin      = 1'($urandom_range(1));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("t4_inflight", 32'(ov[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t4");
    clear_sb();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) step();
    chk("t4_in_ready", 32'(ir[0]), 32'd1);

    // Random traffic: random backpressure first, then free-flowing output.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      a         = pick();
      b         = pick();
      sub       = 1'($urandom_range(1));
      cin       = 1'($urandom_range(1));
      out_ready = (i >= 1200) ? 1'b1 : ($urandom_range(3) != 0);
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
